// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave byte interface. SCLK/MOSI/CS_N are synchronised into sysClk,
// received bytes are deserialised MSB-first and strobed out, and response bytes
// are taken from a one-deep valid/ready holding register and shifted onto MISO.
module spi_slave_byte_if #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] spi_byte,
  output logic       spi_input_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_active,
  output logic       frame_abort,
  output logic       tx_underrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic [1:0]             settle_q;
  logic                   armed_q;
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             rx_sr_q;
  logic [7:0]             byte_q;
  logic                   valid_q, abort_q, under_q;
  logic [6:0]             tx_sr_q;
  logic                   miso_q;
  logic [7:0]             hold_q;
  logic                   ready_q;

  logic sclk_s, mosi_s, csn_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic accept, load, shift;
  logic [7:0] load_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // A CS fall only counts once CS has been seen high after reset, so a reset
  // taken mid-frame does not fabricate a new frame start.
  assign cs_fall   = armed_q & ~csn_s & csn_prev_q;
  assign cs_rise   = csn_s & ~csn_prev_q;

  assign accept    = tx_valid & ready_q;
  assign load      = ((state_q == IDLE) & cs_fall) |
                     ((state_q == ACTIVE) & ~cs_rise & sclk_fall & (bit_cnt_q == 3'd0));
  assign shift     = (state_q == ACTIVE) & ~cs_rise & sclk_fall;
  assign load_byte = ready_q ? IDLE_TX_BYTE : hold_q;

  assign spi_miso        = miso_q;
  assign spi_miso_oe     = (state_q == ACTIVE);
  assign frame_active    = (state_q == ACTIVE);
  assign spi_byte        = byte_q;
  assign spi_input_valid = valid_q;
  assign tx_ready        = ready_q;
  assign frame_abort     = abort_q;
  assign tx_underrun     = under_q;

  // Input synchronisers plus one extra registered copy for edge detection.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  // Arm CS-fall detection once the synchroniser has flushed and shows CS high.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else if (settle_q != 2'(SYNC_STAGES)) begin
      settle_q <= settle_q + 2'd1;
    end else if (csn_s && csn_prev_q) begin
      armed_q  <= 1'b1;
    end
  end

  // Holding register and MISO shifter; a load uses the old holding contents.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      hold_q  <= '0;
      ready_q <= 1'b1;
      tx_sr_q <= '0;
      miso_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      under_q <= 1'b0;
      if (load && !ready_q) begin
        ready_q <= 1'b1;
      end else if (accept) begin
        hold_q  <= tx_byte;
        ready_q <= 1'b0;
      end
      if (load) begin
        tx_sr_q <= load_byte[6:0];
        miso_q  <= load_byte[7];
        under_q <= ready_q;
      end else if (shift) begin
        tx_sr_q <= {tx_sr_q[5:0], 1'b0};
        miso_q  <= tx_sr_q[6];
      end
    end
  end

  // Frame FSM and receive deserialiser; CS rise takes priority over SCLK edges.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            bit_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            abort_q   <= (bit_cnt_q != 3'd0);
            bit_cnt_q <= '0;
          end else if (sclk_rise) begin
            rx_sr_q   <= {rx_sr_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_q  <= {rx_sr_q, mosi_s};
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed bench for spi_slave_byte_if: single-byte frame vectors from a table,
// then hand sequences for latency, multi-byte frames, abort, mid-frame reset,
// idle SCLK and a random-phase 8x-ratio soak.
module tb_spi_slave_byte_if;
  localparam int SYNC = 2;

  logic       sysClk = 1'b0, reset = 1'b1;
  logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, spi_input_valid, tx_ready;
  logic       frame_active, frame_abort, tx_underrun;
  logic [7:0] spi_byte;

  spi_slave_byte_if #(.SYNC_STAGES(SYNC), .IDLE_TX_BYTE(8'h00)) dut (
    .sysClk(sysClk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .spi_byte(spi_byte), .spi_input_valid(spi_input_valid), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_active(frame_active),
    .frame_abort(frame_abort), .tx_underrun(tx_underrun)
  );

  always #5 sysClk = ~sysClk;

  int checks = 0, errors = 0, cyc = 0;
  int n_abort = 0, n_under = 0;
  logic [7:0] rx_log[$];
  int rx_cyc[$];

  always @(posedge sysClk) cyc++;

  // Passive monitor: logs strobed bytes with their cycle, counts pulses.
  always @(negedge sysClk) begin
    if (!reset) begin
      if (spi_input_valid) begin
        rx_log.push_back(spi_byte);
        rx_cyc.push_back(cyc);
      end
      if (frame_abort) n_abort++;
      if (tx_underrun) n_under++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] got(input int idx);
    if (idx < rx_log.size()) return 32'(rx_log[idx]);
    return 32'hDEAD;
  endfunction

  // Master-side shift of n bits, MSB first, 40 ns half period (8x sysClk).
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      #40;
      spi_sclk = 1'b1;
      mi[i] = spi_miso;
      #40;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_fall(input int off);
    #1;
    @(negedge sysClk);
    #(off);
    spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_rise();
    #40;
    spi_cs_n = 1'b1;
    #80;
  endtask

  task automatic preload(input logic [7:0] b);
    #1;
    @(negedge sysClk);
    chk("preload_ready_hi", 32'(tx_ready), 1);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(negedge sysClk);
    tx_valid = 1'b0;
    chk("preload_ready_lo", 32'(tx_ready), 0);
  endtask

  typedef struct {
    bit         pre;
    logic [7:0] txb;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_under;
  } vec_t;

  vec_t vecs[6];
  int   offs[8];

  initial begin
    logic [7:0] mi, m1, m2;
    logic [7:0] rexp[$];
    int n0, u0, a0, t_rise, d;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 1};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1};
    vecs[3] = '{1'b1, 8'h81, 8'h5A, 8'h5A, 8'h81, 1};
    vecs[4] = '{1'b0, 8'h00, 8'h80, 8'h80, 8'h00, 2};
    vecs[5] = '{1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 1};
    offs = '{1, 2, 3, 4, 6, 7, 8, 9};

    // Reset values
    repeat (4) @(negedge sysClk);
    chk("rst_byte", 32'(spi_byte), 0);
    chk("rst_valid", 32'(spi_input_valid), 0);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_oe", 32'(spi_miso_oe), 0);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_active", 32'(frame_active), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    chk("rst_under", 32'(tx_underrun), 0);
    reset = 1'b0;
    repeat (6) @(negedge sysClk);

    // Single frame 0xA5 with strobe latency measured from the 8th SCLK rise
    n0 = rx_log.size();
    cs_fall(0);
    chk("t1_active", 32'(frame_active), 1);
    chk("t1_oe", 32'(spi_miso_oe), 1);
    spi_bits(8'hA5, 7, mi);
    spi_mosi = 1'b1;
    #40;
    spi_sclk = 1'b1;
    t_rise = cyc;
    #40;
    spi_sclk = 1'b0;
    cs_rise();
    chk("t1_count", 32'(rx_log.size() - n0), 1);
    chk("t1_byte", got(n0), 'hA5);
    d = (rx_cyc.size() > n0) ? rx_cyc[n0] - t_rise : -1;
    chk("t1_latency_ok", 32'(d >= SYNC && d <= SYNC + 2), 1);

    // Table of single-byte frames
    for (int v = 0; v < 6; v++) begin
      n0 = rx_log.size(); u0 = n_under; a0 = n_abort;
      if (vecs[v].pre) preload(vecs[v].txb);
      cs_fall(0);
      spi_bits(vecs[v].mosi, 8, mi);
      cs_rise();
      chk("vec_count", 32'(rx_log.size() - n0), 1);
      chk("vec_rx", got(n0), 32'(vecs[v].exp_rx));
      chk("vec_miso", 32'(mi), 32'(vecs[v].exp_miso));
      chk("vec_underrun", 32'(n_under - u0), 32'(vecs[v].exp_under));
      chk("vec_no_abort", 32'(n_abort - a0), 0);
      chk("vec_ready", 32'(tx_ready), 1);
      chk("vec_oe", 32'(spi_miso_oe), 0);
    end

    // Nine back-to-back bytes in one frame
    begin
      logic [7:0] pat[9];
      pat = '{8'h01, 8'h10, 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C};
      n0 = rx_log.size(); a0 = n_abort;
      cs_fall(0);
      for (int i = 0; i < 9; i++) spi_bits(pat[i], 8, mi);
      cs_rise();
      chk("t2_count", 32'(rx_log.size() - n0), 9);
      for (int i = 0; i < 9; i++) chk("t2_byte", got(n0 + i), 32'(pat[i]));
      chk("t2_no_abort", 32'(n_abort - a0), 0);
    end

    // Preloaded response then underrun on the second byte
    n0 = rx_log.size(); u0 = n_under;
    preload(8'h3C);
    cs_fall(0);
    chk("t3_ready_back", 32'(tx_ready), 1);
    spi_bits(8'h11, 8, m1);
    spi_bits(8'h22, 8, m2);
    cs_rise();
    chk("t3_miso0", 32'(m1), 'h3C);
    chk("t3_miso1", 32'(m2), 'h00);
    chk("t3_underrun", 32'(n_under - u0), 2);
    chk("t3_count", 32'(rx_log.size() - n0), 2);

    // Abort after 5 bits, then a clean 0x7E frame
    n0 = rx_log.size(); a0 = n_abort;
    cs_fall(0);
    spi_bits(8'hFF, 5, mi);
    cs_rise();
    chk("t4_abort", 32'(n_abort - a0), 1);
    chk("t4_no_strobe", 32'(rx_log.size() - n0), 0);
    chk("t4_byte_kept", 32'(spi_byte), 'h22);
    cs_fall(0);
    spi_bits(8'h7E, 8, mi);
    cs_rise();
    chk("t4_next_byte", got(n0), 'h7E);
    chk("t4_abort_once", 32'(n_abort - a0), 1);

    // Reset after 3 bits; frame resumes only after a fresh CS fall
    cs_fall(0);
    spi_bits(8'hFF, 3, mi);
    #1;
    @(negedge sysClk);
    reset = 1'b1;
    repeat (2) @(negedge sysClk);
    chk("t5_byte", 32'(spi_byte), 0);
    chk("t5_valid", 32'(spi_input_valid), 0);
    chk("t5_miso", 32'(spi_miso), 0);
    chk("t5_oe", 32'(spi_miso_oe), 0);
    chk("t5_ready", 32'(tx_ready), 1);
    chk("t5_active", 32'(frame_active), 0);
    chk("t5_abort", 32'(frame_abort), 0);
    chk("t5_under", 32'(tx_underrun), 0);
    reset = 1'b0;
    n0 = rx_log.size(); a0 = n_abort;
    spi_bits(8'hAA, 8, mi);
    chk("t5_held_cs_no_strobe", 32'(rx_log.size() - n0), 0);
    chk("t5_held_cs_inactive", 32'(frame_active), 0);
    spi_cs_n = 1'b1;
    #80;
    cs_fall(0);
    spi_bits(8'hC3, 8, mi);
    cs_rise();
    chk("t5_count", 32'(rx_log.size() - n0), 1);
    chk("t5_rx", got(n0), 'hC3);
    chk("t5_no_abort", 32'(n_abort - a0), 0);

    // SCLK toggled with CS high
    n0 = rx_log.size();
    spi_bits(8'h96, 8, mi);
    spi_bits(8'h69, 8, mi);
    chk("t6_idle_no_strobe", 32'(rx_log.size() - n0), 0);
    chk("t6_idle_oe", 32'(spi_miso_oe), 0);
    chk("t6_idle_active", 32'(frame_active), 0);

    // 1000 random bytes, 100 frames, random sub-cycle phase per frame
    n0 = rx_log.size();
    for (int f = 0; f < 100; f++) begin
      cs_fall(offs[$urandom_range(0, 7)]);
      for (int b = 0; b < 10; b++) begin
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        rexp.push_back(r);
        spi_bits(r, 8, mi);
      end
      cs_rise();
    end
    chk("t6_rand_count", 32'(rx_log.size() - n0), 1000);
    for (int i = 0; i < 1000; i++) chk("t6_rand_byte", got(n0 + i), 32'(rexp[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
